// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by ifetch_unit and ifetch_next_pc.
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    FAULT
  } state_t;

  localparam logic [31:0] INST_NOP = 32'h00000013;

endpackage

// File: rtl/ifetch_next_pc.sv
// Redirect target, priority and misalignment check for fetch.
// Purely combinational; sequencing lives in ifetch_unit.
module ifetch_next_pc
  import ifetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            valid,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] dpc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] target,
  output logic            taken,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_sum;

  always_comb begin
    jalr_sum = rs1_val + imm;
    taken    = valid & ~stall
             & (jal | jalr | (branch & zero));
    target   = dpc + imm;
    if (jalr) begin
      target = jalr_sum & ~XLEN'(1);
    end
    misaligned = taken & (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the fetch PC, drives a 1-cycle ROM and
// presents one instruction per cycle to decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jal,
  input  logic              jalr,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   rs1_val,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              inst_valid,
  output logic              fetch_fault
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic [31:0]     hold_q, hold_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] target;
  logic            taken;
  logic            misaligned;
  logic            unused_fpc;

  assign rom_addr    = fpc_q[ADDR_W+1:2];
  assign unused_fpc  = ^{fpc_q[XLEN-1:ADDR_W+2], fpc_q[1:0]};
  assign inst_valid  = (state_q == RUN) || (state_q == HOLD);
  assign inst_pc     = dpc_q;
  assign pc_plus4    = dpc_q + XLEN'(4);
  assign fetch_fault = fault_q;

  always_comb begin
    inst = INST_NOP;
    if (state_q == RUN) begin
      inst = rom_data;
    end else if (state_q == HOLD) begin
      inst = hold_q;
    end
  end

  ifetch_next_pc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .valid     (inst_valid),
    .stall     (stall),
    .branch    (branch),
    .zero      (zero),
    .jal       (jal),
    .jalr      (jalr),
    .dpc       (dpc_q),
    .imm       (imm),
    .rs1_val   (rs1_val),
    .target    (target),
    .taken     (taken),
    .misaligned(misaligned)
  );

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    dpc_d   = dpc_q;
    hold_d  = hold_q;
    fault_d = fault_q;
    unique case (state_q)
      BOOT: begin
        dpc_d   = fpc_q;
        fpc_d   = fpc_q + XLEN'(4);
        state_d = RUN;
      end
      RUN, HOLD: begin
        if (stall) begin
          // ROM word only exists this cycle; capture it once.
          if (state_q == RUN) begin
            hold_d = rom_data;
          end
          state_d = HOLD;
        end else if (misaligned) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else if (taken) begin
          fpc_d   = target;
          state_d = BOOT;
        end else begin
          dpc_d   = fpc_q;
          fpc_d   = fpc_q + XLEN'(4);
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      dpc_q   <= RESET_PC;
      hold_q  <= INST_NOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      dpc_q   <= dpc_d;
      hold_q  <= hold_d;
      fault_q <= fault_d;
    end
  end

endmodule
